pipeline_control_unit: RTL and testbench

Central hazard and sequencing controller for the five-stage RV64 pipeline. It produces the operand-forwarding selects for the execute-stage ALU muxes, the front-end stall and pipeline flush controls, and the next-PC select. It also sequences load-use bubbles, branch/jump redirects, interrupt entry (drain, then trap) and mret return. It sits beside the execute stage and drives its `stall_signal_in`, `flush_signal_in`, `alu_mux*_src_signal_in`, `interrupt_signal_in` and `return_interrupt_signal_in`.

---
 rtl/pipeline_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control_unit
// Brief    : Hazard/sequencing controller for the 5-stage RV64 pipeline:
//            forwarding selects, stall/flush, next-PC select, trap/mret entry.
// Revision : 1.0
// ============================================================================
module pipeline_control_unit (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [4:0] id_rs1_in,
    input  logic [4:0] id_rs2_in,
    input  logic       id_rs1_used_signal_in,
    input  logic       id_rs2_used_signal_in,
    input  logic [4:0] ex_rs1_in,
    input  logic [4:0] ex_rs2_in,
    input  logic [4:0] ex_rd_in,
    input  logic       ex_rd_write_signal_in,
    input  logic       ex_read_signal_in,
    input  logic [4:0] mem_rd_in,
    input  logic       mem_rd_write_signal_in,
    input  logic [4:0] wb_rd_in,
    input  logic       wb_rd_write_signal_in,
    input  logic       branch_jump_signal_in,
    input  logic       mret_signal_in,
    input  logic       interrupt_request_in,
    input  logic       mem_busy_signal_in,
    output logic [1:0] alu_mux1_src_signal_out,
    output logic [1:0] alu_mux2_src_signal_out,
    output logic       stall_signal_out,
    output logic       id_flush_signal_out,
    output logic       flush_signal_out,
    output logic       interrupt_signal_out,
    output logic       return_interrupt_signal_out,
    output logic [1:0] pc_sel_signal_out
);

    localparam logic [2:0] c_ST_RUN        = 3'd0;
    localparam logic [2:0] c_ST_LOAD_STALL = 3'd1;
    localparam logic [2:0] c_ST_REDIRECT   = 3'd2;
    localparam logic [2:0] c_ST_IRQ_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_IRQ_ENTER  = 3'd4;
    localparam logic [2:0] c_ST_MRET       = 3'd5;

    localparam logic [1:0] c_FWD_REG = 2'd0;
    localparam logic [1:0] c_FWD_MEM = 2'd1;
    localparam logic [1:0] c_FWD_WB  = 2'd2;

    localparam logic [1:0] c_PC_SEQ    = 2'd0;
    localparam logic [1:0] c_PC_BRANCH = 2'd1;
    localparam logic [1:0] c_PC_TRAP   = 2'd2;
    localparam logic [1:0] c_PC_MEPC   = 2'd3;

    localparam logic [1:0] c_DRAIN_CYCLES = 2'd2;

    logic [2:0] r_state;
    logic [1:0] r_drain_cnt;

    logic [2:0] w_state_nxt;
    logic [1:0] w_drain_cnt_nxt;
    logic       w_load_use;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;
    logic       w_stall;
    logic       w_id_flush;
    logic       w_flush;
    logic       w_irq;
    logic       w_ret;
    logic [1:0] w_pc_sel;

    // EX/MEM result is younger than MEM/WB, so it wins; x0 is hardwired zero.
    function automatic logic [1:0] f_fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_wr,
        input logic [4:0] wb_rd,
        input logic       wb_wr
    );
        if (rs == 5'd0)
            f_fwd_sel = c_FWD_REG;
        else if (mem_wr && (mem_rd == rs))
            f_fwd_sel = c_FWD_MEM;
        else if (wb_wr && (wb_rd == rs))
            f_fwd_sel = c_FWD_WB;
        else
            f_fwd_sel = c_FWD_REG;
    endfunction

    assign w_fwd1 = f_fwd_sel(ex_rs1_in, mem_rd_in, mem_rd_write_signal_in,
                              wb_rd_in, wb_rd_write_signal_in);
    assign w_fwd2 = f_fwd_sel(ex_rs2_in, mem_rd_in, mem_rd_write_signal_in,
                              wb_rd_in, wb_rd_write_signal_in);

    assign w_load_use = ex_read_signal_in && ex_rd_write_signal_in && (ex_rd_in != 5'd0) &&
                        ((id_rs1_used_signal_in && (id_rs1_in == ex_rd_in)) ||
                         (id_rs2_used_signal_in && (id_rs2_in == ex_rd_in)));

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_stall         = 1'b0;
        w_id_flush      = 1'b0;
        w_flush         = 1'b0;
        w_irq           = 1'b0;
        w_ret           = 1'b0;
        w_pc_sel        = c_PC_SEQ;

        case (r_state)
            c_ST_RUN: begin
                if (mret_signal_in) begin
                    w_state_nxt = c_ST_MRET;
                end else if (branch_jump_signal_in) begin
                    w_pc_sel    = c_PC_BRANCH;
                    w_flush     = 1'b1;
                    w_state_nxt = c_ST_REDIRECT;
                end else if (interrupt_request_in) begin
                    w_stall         = 1'b1;
                    w_id_flush      = 1'b1;
                    w_drain_cnt_nxt = c_DRAIN_CYCLES;
                    w_state_nxt     = c_ST_IRQ_DRAIN;
                end else if (w_load_use) begin
                    w_stall     = 1'b1;
                    w_id_flush  = 1'b1;
                    w_state_nxt = c_ST_LOAD_STALL;
                end
            end
            c_ST_LOAD_STALL: begin
                w_state_nxt = c_ST_RUN;
            end
            c_ST_REDIRECT: begin
                w_flush     = 1'b1;
                w_state_nxt = c_ST_RUN;
            end
            c_ST_IRQ_DRAIN: begin
                // Only bubbles reach execute here, so a branch strobe is ignored.
                w_stall    = 1'b1;
                w_id_flush = 1'b1;
                if (r_drain_cnt <= 2'd1) begin
                    w_drain_cnt_nxt = 2'd0;
                    w_state_nxt     = c_ST_IRQ_ENTER;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 2'd1;
                end
            end
            c_ST_IRQ_ENTER: begin
                w_irq       = 1'b1;
                w_pc_sel    = c_PC_TRAP;
                w_flush     = 1'b1;
                w_state_nxt = c_ST_RUN;
            end
            c_ST_MRET: begin
                w_ret       = 1'b1;
                w_pc_sel    = c_PC_MEPC;
                w_flush     = 1'b1;
                w_state_nxt = c_ST_RUN;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase

        // Memory freeze: hold everything; strobes/redirects are replayed once busy drops.
        if (mem_busy_signal_in) begin
            w_stall         = 1'b1;
            w_id_flush      = 1'b0;
            w_flush         = 1'b0;
            w_irq           = 1'b0;
            w_ret           = 1'b0;
            w_pc_sel        = c_PC_SEQ;
            w_state_nxt     = r_state;
            w_drain_cnt_nxt = r_drain_cnt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= c_ST_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    assign alu_mux1_src_signal_out     = rst_in ? c_FWD_REG : w_fwd1;
    assign alu_mux2_src_signal_out     = rst_in ? c_FWD_REG : w_fwd2;
    assign stall_signal_out            = !rst_in && w_stall;
    assign id_flush_signal_out         = !rst_in && w_id_flush;
    assign flush_signal_out            = !rst_in && w_flush;
    assign interrupt_signal_out        = !rst_in && w_irq;
    assign return_interrupt_signal_out = !rst_in && w_ret;
    assign pc_sel_signal_out           = rst_in ? c_PC_SEQ : w_pc_sel;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_control_unit
// Brief    : Directed self-checking bench for pipeline_control_unit.
// Revision : 1.0
// ============================================================================
module tb_pipeline_control_unit;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [4:0] id_rs1_in, id_rs2_in, ex_rs1_in, ex_rs2_in, ex_rd_in, mem_rd_in, wb_rd_in;
    logic       id_rs1_used_signal_in, id_rs2_used_signal_in;
    logic       ex_rd_write_signal_in, ex_read_signal_in;
    logic       mem_rd_write_signal_in, wb_rd_write_signal_in;
    logic       branch_jump_signal_in, mret_signal_in, interrupt_request_in, mem_busy_signal_in;
    logic [1:0] mux1, mux2, pc_sel;
    logic       stall, id_flush, flush, intr, ret;

    int errors = 0;
    int checks = 0;

    pipeline_control_unit dut (
        .clk_in                      (clk_in),
        .rst_in                      (rst_in),
        .id_rs1_in                   (id_rs1_in),
        .id_rs2_in                   (id_rs2_in),
        .id_rs1_used_signal_in       (id_rs1_used_signal_in),
        .id_rs2_used_signal_in       (id_rs2_used_signal_in),
        .ex_rs1_in                   (ex_rs1_in),
        .ex_rs2_in                   (ex_rs2_in),
        .ex_rd_in                    (ex_rd_in),
        .ex_rd_write_signal_in       (ex_rd_write_signal_in),
        .ex_read_signal_in           (ex_read_signal_in),
        .mem_rd_in                   (mem_rd_in),
        .mem_rd_write_signal_in      (mem_rd_write_signal_in),
        .wb_rd_in                    (wb_rd_in),
        .wb_rd_write_signal_in       (wb_rd_write_signal_in),
        .branch_jump_signal_in       (branch_jump_signal_in),
        .mret_signal_in              (mret_signal_in),
        .interrupt_request_in        (interrupt_request_in),
        .mem_busy_signal_in          (mem_busy_signal_in),
        .alu_mux1_src_signal_out     (mux1),
        .alu_mux2_src_signal_out     (mux2),
        .stall_signal_out            (stall),
        .id_flush_signal_out         (id_flush),
        .flush_signal_out            (flush),
        .interrupt_signal_out        (intr),
        .return_interrupt_signal_out (ret),
        .pc_sel_signal_out           (pc_sel)
    );

    always #5 clk_in = ~clk_in;

    task automatic clear_inputs();
        id_rs1_in = 5'd0; id_rs2_in = 5'd0; ex_rs1_in = 5'd0; ex_rs2_in = 5'd0;
        ex_rd_in = 5'd0; mem_rd_in = 5'd0; wb_rd_in = 5'd0;
        id_rs1_used_signal_in = 1'b0; id_rs2_used_signal_in = 1'b0;
        ex_rd_write_signal_in = 1'b0; ex_read_signal_in = 1'b0;
        mem_rd_write_signal_in = 1'b0; wb_rd_write_signal_in = 1'b0;
        branch_jump_signal_in = 1'b0; mret_signal_in = 1'b0;
        interrupt_request_in = 1'b0; mem_busy_signal_in = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        mem_rd_in = 5'd5; mem_rd_write_signal_in = 1'b1; ex_rs1_in = 5'd5;
        branch_jump_signal_in = 1'b1;
        settle();
        checks++; if (mux1 !== 2'd0) begin errors++; $display("FAIL rst_mux1: got %0d expected 0", mux1); end
        checks++; if (flush !== 1'b0 || pc_sel !== 2'd0) begin errors++; $display("FAIL rst_flush_pc: got flush=%0b pc_sel=%0d expected 0/0", flush, pc_sel); end
        tick();
        clear_inputs();
        rst_in = 1'b0;
        settle();
        checks++; if ({stall, id_flush, flush, intr, ret, pc_sel, mux1, mux2} !== 11'd0) begin
            errors++; $display("FAIL rst_idle: got stall=%0b idf=%0b fl=%0b irq=%0b ret=%0b pc=%0d expected all 0",
                                stall, id_flush, flush, intr, ret, pc_sel); end
    endtask

    task automatic test_forwarding();
        mem_rd_in = 5'd5; mem_rd_write_signal_in = 1'b1;
        wb_rd_in = 5'd5;  wb_rd_write_signal_in = 1'b1;
        ex_rs1_in = 5'd5; ex_rs2_in = 5'd5;
        settle();
        checks++; if (mux1 !== 2'd1) begin errors++; $display("FAIL fwd_mem_prio1: got %0d expected 1", mux1); end
        checks++; if (mux2 !== 2'd1) begin errors++; $display("FAIL fwd_mem_prio2: got %0d expected 1", mux2); end
        mem_rd_write_signal_in = 1'b0;
        settle();
        checks++; if (mux1 !== 2'd2) begin errors++; $display("FAIL fwd_wb1: got %0d expected 2", mux1); end
        mem_rd_write_signal_in = 1'b1; mem_rd_in = 5'd0; wb_rd_in = 5'd0; ex_rs1_in = 5'd0;
        settle();
        checks++; if (mux1 !== 2'd0) begin errors++; $display("FAIL fwd_x0: got %0d expected 0", mux1); end
        mem_rd_in = 5'd5; wb_rd_in = 5'd9; ex_rs2_in = 5'd9;
        settle();
        checks++; if (mux2 !== 2'd2) begin errors++; $display("FAIL fwd_wb2: got %0d expected 2", mux2); end
        ex_rs2_in = 5'd12;
        settle();
        checks++; if (mux2 !== 2'd0) begin errors++; $display("FAIL fwd_none: got %0d expected 0", mux2); end
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        ex_read_signal_in = 1'b1; ex_rd_write_signal_in = 1'b1; ex_rd_in = 5'd7;
        id_rs2_in = 5'd7; id_rs2_used_signal_in = 1'b1;
        settle();
        checks++; if (stall !== 1'b1 || id_flush !== 1'b1) begin errors++; $display("FAIL lu_bubble: got stall=%0b idf=%0b expected 1/1", stall, id_flush); end
        tick();
        clear_inputs();
        settle();
        checks++; if (stall !== 1'b0 || id_flush !== 1'b0) begin errors++; $display("FAIL lu_release: got stall=%0b idf=%0b expected 0/0", stall, id_flush); end
        tick();
        ex_read_signal_in = 1'b1; ex_rd_write_signal_in = 1'b1; ex_rd_in = 5'd7;
        id_rs2_in = 5'd7; id_rs2_used_signal_in = 1'b0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unused: got stall=%0b expected 0", stall); end
        id_rs2_used_signal_in = 1'b1; ex_rd_in = 5'd0; id_rs2_in = 5'd0;
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_x0: got stall=%0b expected 0", stall); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch();
        branch_jump_signal_in = 1'b1;
        settle();
        checks++; if (flush !== 1'b1 || pc_sel !== 2'd1) begin errors++; $display("FAIL br_c1: got flush=%0b pc=%0d expected 1/1", flush, pc_sel); end
        tick();
        branch_jump_signal_in = 1'b0;
        settle();
        checks++; if (flush !== 1'b1 || pc_sel !== 2'd0) begin errors++; $display("FAIL br_c2: got flush=%0b pc=%0d expected 1/0", flush, pc_sel); end
        tick();
        settle();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_done: got flush=%0b expected 0", flush); end
        branch_jump_signal_in = 1'b1;
        ex_read_signal_in = 1'b1; ex_rd_write_signal_in = 1'b1; ex_rd_in = 5'd3;
        id_rs1_in = 5'd3; id_rs1_used_signal_in = 1'b1;
        settle();
        checks++; if (stall !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL br_lu: got stall=%0b flush=%0b expected 0/1", stall, flush); end
        tick();
        clear_inputs();
        settle();
        checks++; if (stall !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL br_lu_c2: got stall=%0b flush=%0b expected 0/1", stall, flush); end
        tick();
    endtask

    task automatic test_interrupt();
        interrupt_request_in = 1'b1;
        settle();
        checks++; if (stall !== 1'b1 || id_flush !== 1'b1 || intr !== 1'b0) begin errors++; $display("FAIL irq_c1: got stall=%0b idf=%0b irq=%0b expected 1/1/0", stall, id_flush, intr); end
        tick();
        branch_jump_signal_in = 1'b1;
        settle();
        checks++; if (stall !== 1'b1 || flush !== 1'b0 || pc_sel !== 2'd0) begin errors++; $display("FAIL irq_c2: got stall=%0b flush=%0b pc=%0d expected 1/0/0", stall, flush, pc_sel); end
        tick();
        branch_jump_signal_in = 1'b0;
        settle();
        checks++; if (stall !== 1'b1 || intr !== 1'b0) begin errors++; $display("FAIL irq_c3: got stall=%0b irq=%0b expected 1/0", stall, intr); end
        tick();
        interrupt_request_in = 1'b0;
        settle();
        checks++; if (intr !== 1'b1 || pc_sel !== 2'd2 || flush !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL irq_enter: got irq=%0b pc=%0d flush=%0b stall=%0b expected 1/2/1/0", intr, pc_sel, flush, stall); end
        tick();
        settle();
        checks++; if (intr !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL irq_done: got irq=%0b stall=%0b expected 0/0", intr, stall); end
    endtask

    task automatic test_irq_after_redirect();
        branch_jump_signal_in = 1'b1; interrupt_request_in = 1'b1;
        settle();
        checks++; if (pc_sel !== 2'd1 || stall !== 1'b0) begin errors++; $display("FAIL rd_irq_c1: got pc=%0d stall=%0b expected 1/0", pc_sel, stall); end
        tick();
        branch_jump_signal_in = 1'b0;
        settle();
        checks++; if (flush !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rd_irq_masked: got flush=%0b stall=%0b expected 1/0", flush, stall); end
        tick();
        settle();
        checks++; if (stall !== 1'b1 || id_flush !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL rd_irq_taken: got stall=%0b idf=%0b flush=%0b expected 1/1/0", stall, id_flush, flush); end
        tick(); tick(); tick();
        interrupt_request_in = 1'b0;
        settle();
        checks++; if (intr !== 1'b1 || pc_sel !== 2'd2) begin errors++; $display("FAIL rd_irq_enter: got irq=%0b pc=%0d expected 1/2", intr, pc_sel); end
        tick();
    endtask

    task automatic test_mret();
        mret_signal_in = 1'b1;
        settle();
        checks++; if (ret !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL mret_c1: got ret=%0b flush=%0b expected 0/0", ret, flush); end
        tick();
        mret_signal_in = 1'b0;
        mem_busy_signal_in = 1'b1;
        settle();
        checks++; if (ret !== 1'b0 || stall !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL mret_busy: got ret=%0b stall=%0b flush=%0b expected 0/1/0", ret, stall, flush); end
        tick();
        mem_busy_signal_in = 1'b0;
        settle();
        checks++; if (ret !== 1'b1 || pc_sel !== 2'd3 || flush !== 1'b1) begin errors++; $display("FAIL mret_strobe: got ret=%0b pc=%0d flush=%0b expected 1/3/1", ret, pc_sel, flush); end
        tick();
        settle();
        checks++; if (ret !== 1'b0 || pc_sel !== 2'd0) begin errors++; $display("FAIL mret_done: got ret=%0b pc=%0d expected 0/0", ret, pc_sel); end
    endtask

    task automatic test_mem_busy();
        interrupt_request_in = 1'b1;
        tick();
        tick();
        interrupt_request_in = 1'b0;
        mem_busy_signal_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (stall !== 1'b1 || intr !== 1'b0 || id_flush !== 1'b0) begin
                errors++; $display("FAIL busy_hold%0d: got stall=%0b irq=%0b idf=%0b expected 1/0/0", i, stall, intr, id_flush); end
            tick();
        end
        mem_busy_signal_in = 1'b0;
        settle();
        checks++; if (stall !== 1'b1 || intr !== 1'b0) begin errors++; $display("FAIL busy_drain_resume: got stall=%0b irq=%0b expected 1/0", stall, intr); end
        tick();
        settle();
        checks++; if (intr !== 1'b1 || pc_sel !== 2'd2) begin errors++; $display("FAIL busy_enter: got irq=%0b pc=%0d expected 1/2", intr, pc_sel); end
        tick();
    endtask

    task automatic test_reset_mid();
        interrupt_request_in = 1'b1;
        tick();
        interrupt_request_in = 1'b0;
        rst_in = 1'b1;
        settle();
        checks++; if (stall !== 1'b0 || id_flush !== 1'b0) begin errors++; $display("FAIL rstmid_during: got stall=%0b idf=%0b expected 0/0", stall, id_flush); end
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if ({stall, id_flush, flush, intr, ret, pc_sel} !== 7'd0) begin
                errors++; $display("FAIL rstmid_idle%0d: got stall=%0b idf=%0b fl=%0b irq=%0b pc=%0d expected all 0", i, stall, id_flush, flush, intr, pc_sel); end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        rst_in = 1'b1;
        tick(); tick();
        test_reset();
        tick();
        test_forwarding();
        test_load_use();
        test_branch();
        test_interrupt();
        tick();
        test_irq_after_redirect();
        test_mret();
        tick();
        test_mem_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete within 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
